// File: rtl/deadtime_gen.sv
`timescale 1ns/1ps
// deadtime_gen: turns one PWM command into complementary high-side/low-side
// gate commands separated by a programmable dead time, with a sticky fault
// shutdown. All outputs are registered and decoded from the next state, so
// the gate pins change on the same edge as the FSM.
module deadtime_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pwm_in,
    input  logic [W-1:0] dead_rise,
    input  logic [W-1:0] dead_fall,
    input  logic         fault,
    input  logic         fault_clr,
    output logic         hs_out,
    output logic         ls_out,
    output logic         dead_active,
    output logic         fault_latched
);

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        DT_HI = 3'd1,
        HI    = 3'd2,
        DT_LO = 3'd3,
        LO    = 3'd4
    } state_t;

    state_t       st;
    state_t       st_nxt;
    logic         pwm_q;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] rise_load;
    logic [W-1:0] fall_load;

    // Dead time D = max(dead_X, 1); the counter holds D-1 on entry so that
    // the DT state lasts exactly D cycles.
    assign rise_load = (dead_rise == '0) ? '0 : dead_rise - W'(1);
    assign fall_load = (dead_fall == '0) ? '0 : dead_fall - W'(1);

    // Next-state and counter logic; shutdown conditions override everything.
    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        if (fault || fault_latched || !ena) begin
            st_nxt = OFF;
        end else begin
            case (st)
                OFF: begin
                    if (pwm_q) begin
                        st_nxt  = DT_HI;
                        cnt_nxt = rise_load;
                    end else begin
                        st_nxt  = DT_LO;
                        cnt_nxt = fall_load;
                    end
                end
                LO: begin
                    if (pwm_q) begin
                        st_nxt  = DT_HI;
                        cnt_nxt = rise_load;
                    end
                end
                HI: begin
                    if (!pwm_q) begin
                        st_nxt  = DT_LO;
                        cnt_nxt = fall_load;
                    end
                end
                DT_HI: begin
                    // A command that reverts during the dead time goes straight
                    // back to the low side: the high side never conducted.
                    if (!pwm_q) begin
                        st_nxt = LO;
                    end else if (cnt == '0) begin
                        st_nxt = HI;
                    end else begin
                        cnt_nxt = cnt - W'(1);
                    end
                end
                DT_LO: begin
                    if (pwm_q) begin
                        st_nxt = HI;
                    end else if (cnt == '0) begin
                        st_nxt = LO;
                    end else begin
                        cnt_nxt = cnt - W'(1);
                    end
                end
                default: st_nxt = OFF;
            endcase
        end
    end

    // State, counter and PWM input register.
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= OFF;
            cnt   <= '0;
            pwm_q <= 1'b0;
        end else begin
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            pwm_q <= pwm_in;
        end
    end

    // Gate outputs decoded from the next state so they move with the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_out      <= 1'b0;
            ls_out      <= 1'b0;
            dead_active <= 1'b0;
        end else begin
            hs_out      <= (st_nxt == HI);
            ls_out      <= (st_nxt == LO);
            dead_active <= (st_nxt == DT_HI) || (st_nxt == DT_LO);
        end
    end

    // Sticky fault flag; a new fault beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else if (fault_clr) begin
            fault_latched <= 1'b0;
        end
    end

endmodule
